complex_frame_accum: RTL and testbench
======================================

COMPLEX_FRAME_ACCUM -- requirements
Module: complex_frame_accum

Interface
REQ-001 SHALL have parameter LEN, default 16: complex elements per frame; legal range 16..1024, power of two.
REQ-002 SHALL have parameter FRAMES, default 4: frames summed per batch; legal range 1..256.
REQ-003 SHALL have port clk, input, 1: the only clock; all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in, input, complex_t: fp32 product from the upstream complex multiplier.
REQ-006 SHALL have port in_valid, input, 1: in carries an element this cycle.
REQ-007 SHALL have port in_sof, input, 1: qualified by in_valid; marks element 0 of frame 0 of a batch.
REQ-008 SHALL have port out, output, complex_t: accumulated element.
REQ-009 SHALL have port out_valid, output, 1: out is valid this cycle.
REQ-010 SHALL have port out_sof, output, 1: out carries element 0 of a batch result.
REQ-011 SHALL have port err, output, 1, present only under ACCUM_ERR_EN: sticky framing error.

Function
REQ-012 SHALL run an FSM with states IDLE, ACCUM and LAST.
REQ-013 SHALL, in IDLE, go to ACCUM on in_valid&&in_sof, or to LAST when FRAMES==1; elem_cnt and frame_cnt start at 0.
REQ-014 SHALL, in IDLE, drop in_valid without in_sof.
REQ-015 SHALL increment elem_cnt (0..LEN-1, wraps to 0) on each accepted element; on wrap, frame_cnt increments.
REQ-016 SHALL go from ACCUM to LAST when frame_cnt reaches FRAMES-1.
REQ-017 SHALL go from LAST to IDLE when element LEN-1 is accepted; a coincident in_sof is accepted as the start of a new batch (back-to-back batches, no bubble).
REQ-018 SHALL compute each element: sum = in + (frame_cnt==0 ? 0 : buf[elem_cnt]) in the complex fp32 adder.
REQ-019 SHALL register in alongside the 1-cycle buffer read, so element-to-sum latency is 12 cycles (1 align + 11 add).
REQ-020 SHALL, for frames 0..FRAMES-2, write sum back to buf[elem_cnt] 12 cycles after acceptance.
REQ-021 SHALL, for frame FRAMES-1, present sum on out with out_valid=1 12 cycles after acceptance, with no write-back.
REQ-022 SHALL have out_sof mark elem 0 of that last frame.
REQ-023 SHALL tolerate gaps in in_valid freely, since LEN>=16 exceeds the 12-cycle read-to-write distance, so no read-after-write hazard exists.
REQ-024 SHALL, on in_sof during ACCUM/LAST at an element other than 0 of frame 0, abort the batch and restart it with this element as element 0 of frame 0.
REQ-025 SHALL still deliver in-flight pipeline results on an abort, and SHALL discard aborted buffer content by the frame-0 zero operand.
REQ-026 SHALL not flag Inf/NaN sums; the adder's own rules apply.

Reset
REQ-027 SHALL, on reset low, force state=IDLE, elem_cnt=0, frame_cnt=0, the valid/sof/last-frame shift pipeline=0, out_valid=0, out_sof=0 and err=0, asynchronously.
REQ-028 SHALL not reset out data or buffer contents.
REQ-029 SHALL, on reset mid-batch, produce no out_valid until a new batch's last frame.

Configuration
REQ-030 SHALL, when ACCUM_ERR_EN is defined, provide port err, set on an in_valid dropped in IDLE or on a REQ-024 abort, and cleared only by reset.
REQ-031 SHALL, when ACCUM_ERR_EN is undefined, have no err port and no detection logic, with identical datapath behaviour.

Structure
REQ-032 SHALL keep complex_t, ADD_LAT=11, RD_LAT=1 and the FSM state enum in the shared package accum_pkg.
REQ-033 SHALL use one sub-module, accum_buf: simple dual-port LEN x 64-bit RAM with registered read.
REQ-034 SHALL reuse the existing complex adder for arithmetic.

Verification
REQ-035 SHALL cover: LEN=16, FRAMES=4, every element (1.0,-1.0)=(3F800000,BF800000), continuous -> 16 outs (40800000,C0800000); first out_valid 12 cycles after frame-3 elem 0; out_sof on first only.
REQ-036 SHALL cover: element k of frame f = (k,f) as fp32, random in_valid gaps -> out[k]=(4k,6), order preserved.
REQ-037 SHALL cover: two batches back-to-back, second all 2.0 -> second result all 8.0 (41000000), no stale first-batch data.
REQ-038 SHALL cover: in_sof at frame 1 elem 5 -> restart; result equals a clean 4-frame batch from that element; err=1 with ACCUM_ERR_EN.
REQ-039 SHALL cover: in_valid without in_sof in IDLE -> no state change, no out_valid; err=1 with ACCUM_ERR_EN, no err port without.
REQ-040 SHALL cover: reset low during frame 2 -> out_valid=0 immediately and stays 0; the next full batch is correct.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types and constants for the complex frame accumulator.
//   complex_t : packed fp32 complex value, re in [63:32], im in [31:0]
//   ADD_LAT   : latency of the complex fp32 adder (cycles)
//   RD_LAT    : latency of the accumulation buffer read (cycles)
//   state_e   : accumulator FSM states
//   fp32_add  : IEEE-754 binary32 addition, round-to-nearest-even,
//               subnormals flushed to zero, quiet NaN propagation
package accum_pkg;

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  localparam int ADD_LAT = 11;
  localparam int RD_LAT  = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    LAST
  } state_e;

  function automatic logic [31:0] fp32_add(input logic [31:0] a, input logic [31:0] b);
    logic        sl, ss;
    logic [7:0]  el, es, d;
    logic [26:0] ml, ms, ms_al, mask, m;
    logic [27:0] sum;
    logic [24:0] mant;
    logic        rnd;
    int          e, lz;
    if (a[30:23] == 8'hFF && a[22:0] != '0) return a | 32'h0040_0000;
    if (b[30:23] == 8'hFF && b[22:0] != '0) return b | 32'h0040_0000;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'd0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    // Larger magnitude operand first; mantissas carry guard/round/sticky bits.
    if (a[30:0] >= b[30:0]) begin
      sl = a[31]; el = a[30:23]; ml = {1'b1, a[22:0], 3'b000};
      ss = b[31]; es = b[30:23]; ms = {1'b1, b[22:0], 3'b000};
    end else begin
      sl = b[31]; el = b[30:23]; ml = {1'b1, b[22:0], 3'b000};
      ss = a[31]; es = a[30:23]; ms = {1'b1, a[22:0], 3'b000};
    end
    d     = el - es;
    mask  = (27'd1 << d) - 27'd1;
    ms_al = (ms >> d) | {26'd0, |(ms & mask)};
    if (sl == ss) sum = {1'b0, ml} + {1'b0, ms_al};
    else          sum = {1'b0, ml} - {1'b0, ms_al};
    if (sum == '0) return 32'd0;
    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = int'(el) + 1;
    end else begin
      lz = 0;
      for (int i = 0; i < 27; i++) if (sum[i]) lz = 26 - i;
      m = sum[26:0] << lz;
      e = int'(el) - lz;
    end
    if (e <= 0) return {sl, 31'd0};
    rnd  = m[2] & (m[3] | m[1] | m[0]);
    mant = {1'b0, m[26:3]} + {24'd0, rnd};
    if (mant[24]) e = e + 1;
    if (e >= 255) return {sl, 8'hFF, 23'd0};
    return {sl, e[7:0], mant[24] ? mant[23:1] : mant[22:0]};
  endfunction

endpackage

// File: rtl/complex_frame_accum_if.sv
// Streaming bus of the complex frame accumulator.
//   in / in_valid / in_sof    : element stream from the complex multiplier
//   out / out_valid / out_sof : accumulated batch result stream
// master drives the input stream, slave (the accumulator) drives the result.
interface complex_frame_accum_if;
  import accum_pkg::*;

  complex_t in;
  logic     in_valid;
  logic     in_sof;
  complex_t out;
  logic     out_valid;
  logic     out_sof;

  modport master (output in, in_valid, in_sof, input out, out_valid, out_sof);
  modport slave  (input in, in_valid, in_sof, output out, out_valid, out_sof);
endinterface

// File: rtl/accum_buf.sv
// Accumulation buffer: simple dual-port LEN x 64-bit RAM, registered read.
//   clk       : clock
//   wr_en_i   : write strobe;  wr_addr_i / wr_data_i : write port
//   rd_en_i   : read strobe;   rd_addr_i            : read address
//   rd_data_o : read data, one cycle after rd_en_i
module accum_buf #(
  parameter int LEN = 16
) (
  input  logic                   clk,
  input  logic                   wr_en_i,
  input  logic [$clog2(LEN)-1:0] wr_addr_i,
  input  logic [63:0]            wr_data_i,
  input  logic                   rd_en_i,
  input  logic [$clog2(LEN)-1:0] rd_addr_i,
  output logic [63:0]            rd_data_o
);
  logic [63:0] mem_q [LEN];
  logic [63:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/complex_fp32_add.sv
// Complex fp32 adder, ADD_LAT cycles from operands to sum, fully pipelined.
//   clk   : clock
//   a_i   : first complex operand
//   b_i   : second complex operand
//   sum_o : a_i + b_i, ADD_LAT cycles later
module complex_fp32_add
  import accum_pkg::*;
(
  input  logic     clk,
  input  complex_t a_i,
  input  complex_t b_i,
  output complex_t sum_o
);
  complex_t pipe_q [ADD_LAT];

  always_ff @(posedge clk) begin
    pipe_q[0].re <= fp32_add(a_i.re, b_i.re);
    pipe_q[0].im <= fp32_add(a_i.im, b_i.im);
    for (int i = 1; i < ADD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end

  assign sum_o = pipe_q[ADD_LAT-1];
endmodule

// File: rtl/complex_frame_accum.sv
// Complex frame accumulator: sums FRAMES consecutive frames of LEN complex
// fp32 elements element-wise and streams out the final frame's sums.
//   clk   : clock (rising edge)
//   reset : asynchronous, active-low reset
//   bus   : complex_frame_accum_if.slave (in/in_valid/in_sof in,
//           out/out_valid/out_sof out)
//   err   : sticky framing error, only when ACCUM_ERR_EN is defined
// Optional feature macro: ACCUM_ERR_EN.
module complex_frame_accum
  import accum_pkg::*;
#(
  parameter int LEN    = 16,
  parameter int FRAMES = 4
) (
  input  logic clk,
  input  logic reset,
  complex_frame_accum_if.slave bus
`ifdef ACCUM_ERR_EN
  ,
  output logic err
`endif
);
  localparam int EW = $clog2(LEN);
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  state_e        state_q, state_d;
  logic [EW-1:0] elem_q, elem_d, cur_elem;
  logic [FW-1:0] frame_q, frame_d, cur_frame;
  logic          accept, restart, last_elem, last_frame;

  // Any in_sof starts a batch at (0,0); elsewhere than IDLE that is an abort.
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    frame_d = frame_q;
    accept  = 1'b0;
    restart = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sof) begin
        accept  = 1'b1;
        restart = 1'b1;
      end else if (state_q != IDLE) begin
        accept = 1'b1;
      end
    end
    cur_elem   = restart ? '0 : elem_q;
    cur_frame  = restart ? '0 : frame_q;
    last_elem  = (cur_elem == EW'(LEN - 1));
    last_frame = (cur_frame == FW'(FRAMES - 1));
    if (accept) begin
      if (last_elem) begin
        elem_d = '0;
        if (last_frame) begin
          frame_d = '0;
          state_d = IDLE;
        end else begin
          frame_d = cur_frame + 1'b1;
          state_d = (frame_d == FW'(FRAMES - 1)) ? LAST : ACCUM;
        end
      end else begin
        elem_d  = cur_elem + 1'b1;
        frame_d = cur_frame;
        state_d = last_frame ? LAST : ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      elem_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      frame_q <= frame_d;
    end
  end

`ifdef ACCUM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (bus.in_valid && ((state_q == IDLE && !bus.in_sof) ||
                                  (state_q != IDLE && bus.in_sof))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

  // ---- stage p0: input registered alongside the buffer read ----
  logic          vld_p0_q, sof_p0_q, last_p0_q, first_p0_q;
  logic [EW-1:0] addr_p0_q;
  complex_t      in_p0_q, rd_data, add_b, sum;

  // ---- stages p1..pADD_LAT: control travelling with the adder ----
  logic [ADD_LAT:1] vld_p_q, sof_p_q, last_p_q;
  logic [EW-1:0]    addr_p_q [1:ADD_LAT];
  logic             wr_en, out_vld;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0_q  <= 1'b0;
      sof_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      vld_p_q   <= '0;
      sof_p_q   <= '0;
      last_p_q  <= '0;
    end else begin
      vld_p0_q  <= accept;
      sof_p0_q  <= (cur_elem == '0);
      last_p0_q <= last_frame;
      vld_p_q   <= {vld_p_q[ADD_LAT-1:1], vld_p0_q};
      sof_p_q   <= {sof_p_q[ADD_LAT-1:1], sof_p0_q};
      last_p_q  <= {last_p_q[ADD_LAT-1:1], last_p0_q};
    end
  end

  always_ff @(posedge clk) begin
    in_p0_q    <= bus.in;
    addr_p0_q  <= cur_elem;
    first_p0_q <= (cur_frame == '0);
    addr_p_q[1] <= addr_p0_q;
    for (int i = 2; i <= ADD_LAT; i++) addr_p_q[i] <= addr_p_q[i-1];
  end

  // Frame 0 adds zero, so whatever an aborted batch left in the buffer is ignored.
  assign add_b = first_p0_q ? '0 : rd_data;

  accum_buf #(.LEN(LEN)) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_p_q[ADD_LAT]),
    .wr_data_i (sum),
    .rd_en_i   (accept),
    .rd_addr_i (cur_elem),
    .rd_data_o (rd_data)
  );

  complex_fp32_add u_add (
    .clk   (clk),
    .a_i   (in_p0_q),
    .b_i   (add_b),
    .sum_o (sum)
  );

  // ---- stage pADD_LAT: write back partial sums or emit the final frame ----
  assign wr_en         = vld_p_q[ADD_LAT] & ~last_p_q[ADD_LAT];
  assign out_vld       = vld_p_q[ADD_LAT] & last_p_q[ADD_LAT];
  assign bus.out       = sum;
  assign bus.out_valid = out_vld;
  assign bus.out_sof   = out_vld & sof_p_q[ADD_LAT];
endmodule

// File: tb/tb_complex_frame_accum.sv
module tb_complex_frame_accum;
  import accum_pkg::*;

  localparam int L   = 16;
  localparam int F   = 4;
  localparam int LAT = 12;

  typedef struct {
    logic [63:0] data;
    logic        sof;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  complex_frame_accum_if bus();
`ifdef ACCUM_ERR_EN
  logic err;
`endif

  complex_frame_accum #(.LEN(L), .FRAMES(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ACCUM_ERR_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] i2f(input int v);
    int          a, e;
    logic [31:0] m;
    if (v == 0) return 32'd0;
    a = (v < 0) ? -v : v;
    e = 0;
    for (int i = 0; i < 31; i++) if (a[i]) e = i;
    m = 32'(a) << (23 - e);
    return {v < 0, 8'(e + 127), m[22:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic sof,
                      input bit expect_out, input logic [31:0] ere, input logic [31:0] eim,
                      input logic esof);
    bus.in.re    = re;
    bus.in.im    = im;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    if (expect_out) sb.push_back('{data: {ere, eim}, sof: esof, due: cyc + LAT});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  // kind 0: (1,-1); 1: (k,f); 2: (2,2); 3: (3,k). Sends the first n elements.
  task automatic batch(input int kind, input int gap_max, input int n);
    int          cnt;
    logic [31:0] re, im, ere, eim;
    cnt = 0;
    for (int f = 0; f < F; f++) begin
      for (int k = 0; k < L; k++) begin
        if (cnt < n) begin
          case (kind)
            0: begin re = 32'h3F800000; im = 32'hBF800000; ere = 32'h40800000; eim = 32'hC0800000; end
            1: begin re = i2f(k); im = i2f(f); ere = i2f(4 * k); eim = i2f(6); end
            2: begin re = i2f(2); im = i2f(2); ere = 32'h41000000; eim = 32'h41000000; end
            default: begin re = i2f(3); im = i2f(k); ere = i2f(12); eim = i2f(4 * k); end
          endcase
          send(re, im, (f == 0 && k == 0), (f == F - 1), ere, eim, (k == 0));
          cnt++;
          if (gap_max > 0) cyc_wait(int'($urandom_range(0, gap_max)));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out observed=%h expected=no_output", bus.out);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", bus.out, mon_e.data);
        check("out_sof", {63'd0, bus.out_sof}, {63'd0, mon_e.sof});
        check("out_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.in       = '0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_sof", {63'd0, bus.out_sof}, 64'd0);
`ifdef ACCUM_ERR_EN
    check("rst_err", {63'd0, err}, 64'd0);
`endif
    reset = 1'b1;
    cyc_wait(2);

    // Constant (1,-1), continuous.
    batch(0, 0, L * F);
    cyc_wait(LAT + 2);

    // (k,f) with random gaps.
    batch(1, 3, L * F);
    cyc_wait(LAT + 2);

    // Back-to-back batches; second must not see first batch data.
    batch(1, 0, L * F);
    batch(2, 0, L * F);
    cyc_wait(LAT + 2);
`ifdef ACCUM_ERR_EN
    check("err_clean", {63'd0, err}, 64'd0);
`endif

    // Abort at frame 1 element 5, restart a clean batch there.
    batch(1, 0, L + 5);
    batch(1, 0, L * F);
    cyc_wait(LAT + 2);
`ifdef ACCUM_ERR_EN
    check("err_abort", {63'd0, err}, 64'd1);
`endif

    // Reset, then in_valid without in_sof in IDLE must be dropped.
    #2 reset = 1'b0;
    cyc_wait(2);
    #2 reset = 1'b1;
    cyc_wait(2);
`ifdef ACCUM_ERR_EN
    check("err_after_rst", {63'd0, err}, 64'd0);
`endif
    send(i2f(7), i2f(7), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    send(i2f(9), i2f(9), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    send(i2f(5), i2f(5), 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc_wait(LAT + 4);
`ifdef ACCUM_ERR_EN
    check("err_idle_drop", {63'd0, err}, 64'd1);
`endif
    batch(3, 0, L * F);
    cyc_wait(LAT + 2);

    // Reset low during frame 2.
    batch(1, 0, 2 * L + 7);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_out_sof", {63'd0, bus.out_sof}, 64'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      cyc_wait(1);
      check("midrst_hold_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    reset = 1'b1;
    cyc_wait(3);
`ifdef ACCUM_ERR_EN
    check("err_midrst", {63'd0, err}, 64'd0);
`endif
    batch(2, 1, L * F);
    cyc_wait(LAT + 6);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
